sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_pkg.sv | 25 ++
 rtl/sipo_shreg.sv | 33 +++
 rtl/sipo_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_pkg.sv
// sipo_frame_pkg
// Shared definitions for the serial-in / parallel-out frame receiver.
//   DATA_W_DEF    : default number of data bits per frame
//   frame_state_t : receiver FSM state encoding
// Optional feature macro: SIPO_FRAME_PARITY_EN (adds the PARITY state).
package sipo_frame_pkg;

    localparam int DATA_W_DEF = 10;

`ifdef SIPO_FRAME_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd3
    } frame_state_t;
`endif

endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg
// DATA_W-bit shift register for the frame receiver. Bits enter at the MSB
// and move toward the LSB, so after DATA_W shifts the first-received bit
// sits in bit 0.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset    : synchronous active-high reset (clears the register)
//   i_shift_en : shift one bit in this cycle
//   i_din      : serial input bit
//   o_q        : current register contents
module sipo_shreg #(
    parameter int DATA_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_shift_en,
    input  logic              i_din,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {i_din, r_q[DATA_W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
// Serial frame receiver: start bit, DATA_W data bits (first bit -> LSB),
// optional even-parity bit, stop bit. One bit is consumed per cycle with
// bit_en=1. A good frame is committed into a holding register offered on a
// valid/ready handshake; sticky flags report bad stop bits, overruns and
// (optionally) parity errors.
// Optional feature macro: SIPO_FRAME_PARITY_EN (PARITY state + parity_err).
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   data_in    : serial line, sampled when bit_en=1
//   bit_en     : bit-time strobe
//   data_out   : held frame word
//   out_valid  : data_out holds an unconsumed word
//   out_ready  : downstream accepts the word when out_valid & out_ready
//   busy       : receiver not in IDLE
//   frame_err  : sticky, stop bit sampled at the wrong level
//   overrun    : sticky, frame completed while holding register full
//   err_clr    : clears sticky flags (a same-cycle set wins)
//   parity_err : sticky, parity mismatch (parity build only)
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int   DATA_W   = DATA_W_DEF,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr
`ifdef SIPO_FRAME_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W);

    frame_state_t      r_state;
    frame_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_shword;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ferr;
    logic              r_ovr;

    logic w_last_bit;
    logic w_busy;
    logic w_start_det;
    logic w_shift_en;
    logic w_stop_smp;
    logic w_commit;
    logic w_bad_stop;
    logic w_accept;
    logic w_handshake;
    logic w_ovr_set;

    assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

    sipo_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_shift_en (w_shift_en),
        .i_din      (data_in),
        .o_q        (w_shword)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: nothing moves without a bit strobe
    always_comb begin
        w_state_nxt = r_state;
        if (bit_en) begin
            case (r_state)
                IDLE: begin
                    if (data_in == ~IDLE_LVL) begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (w_last_bit) begin
`ifdef SIPO_FRAME_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
`ifdef SIPO_FRAME_PARITY_EN
                PARITY:  w_state_nxt = STOP;
`endif
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_start_det = bit_en && (r_state == IDLE) && (data_in == ~IDLE_LVL);
        w_shift_en  = bit_en && (r_state == DATA);
        w_stop_smp  = bit_en && (r_state == STOP);
        w_commit    = w_stop_smp && (data_in == IDLE_LVL);
        w_bad_stop  = w_stop_smp && (data_in != IDLE_LVL);
    end

    assign w_handshake = r_valid && out_ready;
    // A word can land if the register is empty or is being emptied this cycle
    assign w_accept    = w_commit && (!r_valid || out_ready);
    assign w_ovr_set   = w_commit && r_valid && !out_ready;

    // Bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_start_det) begin
            r_cnt <= '0;
        end else if (w_shift_en) begin
            r_cnt <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Holding register and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_shword;
            r_valid <= 1'b1;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky flags: set has priority over clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_bad_stop) begin
                r_ferr <= 1'b1;
            end else if (err_clr) begin
                r_ferr <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (err_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    logic r_perr;
    logic w_par_bad;

    // Even parity: expected parity bit equals XOR of the data bits
    assign w_par_bad = bit_en && (r_state == PARITY) && (data_in != ^w_shword);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perr <= 1'b0;
        end else if (w_par_bad) begin
            r_perr <= 1'b1;
        end else if (err_clr) begin
            r_perr <= 1'b0;
        end
    end

    assign parity_err = r_perr;
`endif

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign busy      = w_busy;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_in;
    logic         bit_en;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic         err_clr;
`ifdef SIPO_FRAME_PARITY_EN
    logic         parity_err;
`endif

    always #5 clk = ~clk;

    sipo_frame_ctrl #(
        .DATA_W   (W),
        .IDLE_LVL (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
`ifdef SIPO_FRAME_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic         m_valid  = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         stop;
        int           gap;
        logic         drain;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_ferr;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; strobes one bit, returns gap cycles later at a negedge
    task automatic send_bit(input logic b, input int gap);
        data_in = b;
        bit_en  = 1'b1;
        @(negedge clk);
        bit_en  = 1'b0;
        data_in = 1'b1;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    // Stop bit always uses gap 1 so the caller samples one cycle after it
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap,
                              input logic par_flip, input logic clr_at_stop,
                              input logic rdy_at_stop);
        check("busy_before_start", busy, 0);
        send_bit(1'b0, gap);
        check("busy_after_start", busy, 1);
        for (int i = 0; i < W; i++) begin
            send_bit(d[i], gap);
            check("busy_data", busy, 1);
        end
`ifdef SIPO_FRAME_PARITY_EN
        send_bit((^d) ^ par_flip, gap);
        check("busy_parity", busy, 1);
`else
        if (par_flip) $display("note: parity flip ignored in this build");
`endif
        err_clr   = clr_at_stop;
        out_ready = rdy_at_stop;
        send_bit(stop, 1);
        err_clr   = 1'b0;
        out_ready = 1'b0;
        check("busy_after_stop", busy, 0);
    endtask

    // Waits (bounded) for a word, compares it with the scoreboard, consumes it
    task automatic drain(input string name);
        logic [W-1:0] e;
        int t = 0;
        while (!out_valid && t < 4) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: got word %0h expected none", name, data_out);
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, data_out, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_clr"}, out_valid, 0);
        m_valid = 1'b0;
    endtask

    logic         line [12];
    logic [W-1:0] w32;
    logic [W-1:0] held;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; data_in = 1'b1; bit_en = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        @(negedge clk);

        //          d       stop gap drn  valid data    ferr ovr
        tbl[0] = '{10'h2A5, 1'b1, 1, 1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0};
        tbl[1] = '{10'h15A, 1'b1, 2, 1'b1, 1'b1, 10'h15A, 1'b0, 1'b0};
        tbl[2] = '{10'h3FF, 1'b1, 4, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0};
        tbl[3] = '{10'h001, 1'b0, 1, 1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0};
        tbl[4] = '{10'h200, 1'b1, 3, 1'b1, 1'b1, 10'h200, 1'b1, 1'b0};
        tbl[5] = '{10'h0F0, 1'b1, 1, 1'b0, 1'b1, 10'h200, 1'b1, 1'b1};

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].drain && m_valid) drain("tbl_drain");
            if (tbl[v].stop && !m_valid) begin
                exp_q.push_back(tbl[v].d);
                m_valid = 1'b1;
            end
            send_frame(tbl[v].d, tbl[v].stop, tbl[v].gap, 1'b0, 1'b0, 1'b0);
            check("tbl_valid", out_valid, tbl[v].exp_valid);
            check("tbl_data", data_out, tbl[v].exp_data);
            check("tbl_ferr", frame_err, tbl[v].exp_ferr);
            check("tbl_ovr", overrun, tbl[v].exp_ovr);
            @(negedge clk);
        end
        drain("tail");

        // Clear racing a bad stop bit: frame_err set wins, overrun clears
        send_frame(10'h155, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        check("setwins_ferr", frame_err, 1);
        check("setwins_ovr", overrun, 0);
        check("setwins_valid", out_valid, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_ferr", frame_err, 0);

        // Raw line stream, strobe every cycle
        line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < W; i++) w32[i] = line[i + 1];
        exp_q.push_back(w32);
        m_valid = 1'b1;
        for (int i = 0; i < 11; i++) send_bit(line[i], 1);
        check("line_valid_pre", out_valid, 0);
        send_bit(line[11], 1);
        check("line_valid", out_valid, 1);
        check("line_ferr", frame_err, 0);
        check("line_busy", busy, 0);
        drain("line");

        // Same word, strobe every 4th cycle
        exp_q.push_back(w32);
        m_valid = 1'b1;
        send_frame(w32, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        check("slow_valid", out_valid, 1);
        drain("slow");

        // Reset after the 5th data bit, with a start-level strobe during reset
        send_bit(1'b0, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
        check("mid_busy", busy, 1);
        reset = 1'b1; bit_en = 1'b1; data_in = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        reset = 1'b0; bit_en = 1'b0; data_in = 1'b1; err_clr = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_data", data_out, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_ferr", frame_err, 0);
        @(negedge clk);
        check("midrst_still_valid0", out_valid, 0);
        exp_q.push_back(10'h1C3);
        m_valid = 1'b1;
        send_frame(10'h1C3, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", out_valid, 1);

        // New word commits while the held one is consumed in the same cycle
        held = exp_q[0];
        check("pre_swap_data", data_out, held);
        void'(exp_q.pop_front());
        exp_q.push_back(10'h0A7);
        send_frame(10'h0A7, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        check("swap_valid", out_valid, 1);
        check("swap_ovr", overrun, 0);
        drain("swap");

`ifdef SIPO_FRAME_PARITY_EN
        exp_q.push_back(10'h3FF);
        send_frame(10'h3FF, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        check("par_bad_perr", parity_err, 1);
        check("par_bad_valid", out_valid, 1);
        drain("par_bad");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("par_clr", parity_err, 0);
        exp_q.push_back(10'h3FF);
        send_frame(10'h3FF, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check("par_ok_perr", parity_err, 0);
        drain("par_ok");
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
